// File: rtl/cc_main_mem_responder.sv
// Main-memory responder for the L1 cache controller's memory port: single-word
// reads/writes answered with a one-cycle ready pulse after a fixed latency.
module cc_main_mem_responder #(
  parameter int          ADDR_W   = 10,
  parameter int          LATENCY  = 4,
  parameter logic [15:0] FILL_TAG = 16'hC0DE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic        wr,
  input  logic [15:0] address,
  input  logic [31:0] data_c_to_mem,
  output logic        ready,
  output logic [31:0] data_mem_to_c,
  output logic        busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic                op_wr_q;
  logic [31:0]         mem [DEPTH];
  logic [DEPTH-1:0]    written_q;

  logic                accept, commit;
  logic [ADDR_W-1:0]   c_idx;
  logic [31:0]         c_data;
  logic                c_wr;

  // Upper address bits alias onto the same word and are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[15:ADDR_W];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (rd || wr) begin
        accept = 1'b1;
        if (LATENCY == 1) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: if (cnt_q == 4'd1) begin
        state_d = RESP;
        commit  = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready = (state_q == RESP);
    busy  = (state_q != IDLE);
  end

  // With LATENCY=1 the commit happens on the accepting edge, straight from the inputs.
  always_comb begin
    c_idx  = idx_q;
    c_data = wdata_q;
    c_wr   = op_wr_q;
    if (state_q == IDLE) begin
      c_idx  = address[ADDR_W-1:0];
      c_data = data_c_to_mem;
      c_wr   = wr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      wdata_q       <= '0;
      op_wr_q       <= 1'b0;
      written_q     <= '0;
      data_mem_to_c <= '0;
    end else begin
      if (accept) begin
        cnt_q   <= 4'(LATENCY - 1);
        idx_q   <= address[ADDR_W-1:0];
        wdata_q <= data_c_to_mem;
        op_wr_q <= wr;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (commit && c_wr)
        written_q[c_idx] <= 1'b1;
      if (commit && !c_wr)
        data_mem_to_c <= written_q[c_idx] ? mem[c_idx]
                                          : {FILL_TAG, 6'b0, 10'(c_idx)};
    end
  end

  // NOTE: the storage array is not reset; the written flags make stale
  // contents invisible, and reset blocks a commit that would race the abort.
  always_ff @(posedge clk) begin
    if (commit && c_wr && !rst)
      mem[c_idx] <= c_data;
  end

endmodule

// File: doc/cc_main_mem_responder.md
Name: cc_main_mem_responder

Overview:
- Synthesizable main-memory responder for the memory-side port of the L1 cache controller.
- It accepts single-word read and write requests from the controller (rd/wr, address, data_c_to_mem).
- After a programmable latency it answers with a one-cycle ready pulse and, for reads, data_mem_to_c.
- It is the counterpart to the controller's memory master and replaces the bench-driven ready/data_mem_to_c stimulus in integrated simulation.

Parameters:
- ADDR_W, 10: number of low address bits used to index memory; DEPTH = 2**ADDR_W words of 32 bits.
- LATENCY, 4: cycles from request acceptance to the ready pulse; legal range 1..15.
- FILL_TAG, 16'hC0DE: upper half of the data returned for never-written words.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- rd  input  1  read request from cache controller.
- wr  input  1  write request from cache controller; the codebase's wr signal.
- address  input  16  word address; only address[ADDR_W-1:0] is used, upper bits are ignored (aliasing).
- data_c_to_mem  input  32  write data, sampled at acceptance.
- ready  output  1  one-cycle completion pulse for the accepted request.
- data_mem_to_c  output  32  read data; valid in the ready cycle and held until the next read completes.
- busy  output  1  high from the cycle after acceptance through the ready cycle.

Behaviour:
- Reset (async, rst=1): ready=0, busy=0, data_mem_to_c=32'h0, FSM=IDLE, latency counter=0, all DEPTH per-word written flags cleared.
  - The memory array itself is not reset.
  - Reset mid-transaction aborts the transaction: no ready pulse, and a pending write is not committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If rd|wr at a rising edge, capture address[ADDR_W-1:0], data_c_to_mem and the operation, load counter=LATENCY-1, then go to WAIT, or to RESP directly when LATENCY=1.
  - wr has priority when rd and wr are both high: the request is treated as a write.
- WAIT: counter decrements each cycle; at counter==1, go to RESP. rd/wr are ignored while in WAIT or RESP.
- RESP:
  - ready=1 for exactly this cycle, then return to IDLE.
  - Write: mem[idx] <= captured data and written[idx] <= 1 at the edge entering RESP, so a read accepted on the next cycle sees the new value.
  - Read: data_mem_to_c = mem[idx] if written[idx], else {FILL_TAG, 6'b0, idx zero-extended to 10 bits}; registered so it is valid in the RESP cycle.
- Latency: request sampled at edge N ⇒ ready high during cycle N+LATENCY.
- Back-to-back: the controller must drop rd/wr in the cycle it sees ready.
  - If rd/wr is still high in the first IDLE cycle after RESP, it is a new request.
  - Minimum spacing between accepted requests is LATENCY+1 cycles.
- busy = (state != IDLE).
- data_mem_to_c:
  - Unchanged by writes.
  - Unchanged by reset-free idle periods.
  - Changes only when a read reaches RESP.
- Address aliasing: address 16'h0405 and 16'h0005 hit the same word when ADDR_W=10.

Test Plan:
- Reset, then rd at address 16'h0012 with LATENCY=4 → ready pulses exactly 4 cycles after acceptance, data_mem_to_c=32'hC0DE0012, busy high for 4 cycles.
- wr address 16'h0030 data 32'hDEADBEEF, then rd 16'h0030 → read returns 32'hDEADBEEF; data_mem_to_c stays 32'hC0DE0012 (the prior read value) through the write.
- rd and wr both high at address 16'h0001 with data 32'h11111111, then rd 16'h0001 → treated as a write; read returns 32'h11111111.
- Assert rst two cycles into a write of 32'hAAAA5555 to 16'h0040 → no ready pulse, busy=0 immediately; a later rd of 16'h0040 returns 32'hC0DE0040.
- Hold rd high continuously at 16'h0405 after writing 32'h12345678 to 16'h0005 → returns 32'h12345678 (aliasing) with ready pulses exactly every LATENCY+1=5 cycles; rd toggling while busy is ignored.
- LATENCY=1 build: wr then rd at 16'h03FF → ready on the cycle after each acceptance; the read returns the written data.
